// File: rtl/rpn_calculator_if.sv
// -----------------------------------------------------------------------------
// rpn_calculator_if
// Key-entry handshake between a key source and the RPN calculator core.
//   key_valid : source presents a key code this cycle
//   key_ready : core can accept a key this cycle
//   key_code  : 0-9 digit, 10 ENTER, 11 ADD, 12 SUB, 13 MUL, 14 NEG,
//               15 DROP, 16 SWAP, 17 CLEAR, 18-31 no effect
// A key transfers on a rising clock edge where key_valid && key_ready.
// -----------------------------------------------------------------------------
interface rpn_calculator_if;
    logic       key_valid;
    logic       key_ready;
    logic [4:0] key_code;

    modport master (
        output key_valid,
        output key_code,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output key_ready
    );
endinterface

// File: rtl/rpn_calculator.sv
// -----------------------------------------------------------------------------
// rpn_calculator
// Stack-based (RPN) calculator core. Keys arrive over a valid/ready handshake
// and operate on a StackDepth-entry register stack; S[0] is the top and drives
// the display path. Multiplication runs as a DataWidth-cycle shift-add.
//
// Ports:
//   clk_i          : clock, rising edge
//   rst_ni         : asynchronous active-low reset
//   key_if         : key handshake (slave side: valid, code in; ready out)
//   top_o          : registered S[0] (0 when the stack is empty)
//   depth_o        : number of valid stack entries
//   entry_active_o : multi-digit number entry in progress on S[0]
//   error_o        : sticky overflow/underflow flag, cleared by CLEAR/reset
//   busy_o         : multiply in progress (keys are not accepted)
// -----------------------------------------------------------------------------
module rpn_calculator #(
    parameter  int NumDigits  = 8,
    parameter  int DataWidth  = 32,
    parameter  int StackDepth = 4,
    localparam int DepthW     = $clog2(StackDepth + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    rpn_calculator_if.slave             key_if,
    output logic signed [DataWidth-1:0] top_o,
    output logic        [DepthW-1:0]    depth_o,
    output logic                        entry_active_o,
    output logic                        error_o,
    output logic                        busy_o
);

    localparam int CntW    = $clog2(NumDigits + 1);
    localparam int MulCntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

    localparam logic [DepthW-1:0]  DepthFull = DepthW'(StackDepth);
    localparam logic [DepthW-1:0]  DepthOne  = DepthW'(1);
    localparam logic [DepthW-1:0]  DepthTwo  = DepthW'(2);
    localparam logic [CntW-1:0]    CntMax    = CntW'(NumDigits);
    localparam logic [CntW-1:0]    CntOne    = CntW'(1);
    localparam logic [MulCntW-1:0] MulLast   = MulCntW'(DataWidth - 1);

    localparam logic [4:0] KeyEnter = 5'd10;
    localparam logic [4:0] KeyAdd   = 5'd11;
    localparam logic [4:0] KeySub   = 5'd12;
    localparam logic [4:0] KeyMul   = 5'd13;
    localparam logic [4:0] KeyNeg   = 5'd14;
    localparam logic [4:0] KeyDrop  = 5'd15;
    localparam logic [4:0] KeySwap  = 5'd16;
    localparam logic [4:0] KeyClear = 5'd17;

    typedef enum logic {
        StIdle,
        StMul
    } state_e;

    // Decimal shift-in: v*10 + d, computed as (v<<3)+(v<<1)+d, wrapping.
    function automatic logic signed [DataWidth-1:0] append_digit(
        input logic signed [DataWidth-1:0] v,
        input logic        [3:0]           d
    );
        logic signed [DataWidth-1:0] x8;
        logic signed [DataWidth-1:0] x2;
        x8 = v <<< 3;
        x2 = v <<< 1;
        return x8 + x2 + $signed({{(DataWidth-4){1'b0}}, d});
    endfunction

    state_e state_q, state_d;

    logic signed [DataWidth-1:0] stack_q [StackDepth];
    logic signed [DataWidth-1:0] stack_d [StackDepth];
    logic        [DepthW-1:0]    depth_q, depth_d;
    logic                        entry_q, entry_d;
    logic        [CntW-1:0]      count_q, count_d;
    logic                        error_q, error_d;

    logic signed [DataWidth-1:0] mcand_q;
    logic signed [DataWidth-1:0] mplier_q;
    logic signed [DataWidth-1:0] acc_q;
    logic        [MulCntW-1:0]   mul_cnt_q;

    logic                        key_acc;
    logic                        mul_start;
    logic                        mul_last;
    logic signed [DataWidth-1:0] mul_partial;
    logic signed [DataWidth-1:0] mul_result;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (mul_start) state_d = StMul;
            StMul:   if (mul_last)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o           = (state_q == StMul);
        key_if.key_ready = (state_q != StMul);
    end

    assign key_acc  = key_if.key_valid && key_if.key_ready;
    assign mul_last = (state_q == StMul) && (mul_cnt_q == MulLast);

    // ---------------------------------------------------------- multiplier
    // Low DataWidth bits of a two's-complement product equal those of the
    // unsigned product, so a plain unsigned shift-add is sufficient.
    // The last iteration's partial sum is folded into mul_result, so the
    // stack is updated on the DataWidth-th edge after acceptance.
    assign mul_partial = mplier_q[0] ? mcand_q : '0;
    assign mul_result  = acc_q + mul_partial;

    always_ff @(posedge clk_i) begin
        if (mul_start) begin
            mcand_q   <= stack_q[1];
            mplier_q  <= stack_q[0];
            acc_q     <= '0;
            mul_cnt_q <= '0;
        end else if (state_q == StMul) begin
            acc_q     <= mul_result;
            mcand_q   <= mcand_q <<< 1;
            mplier_q  <= $signed($unsigned(mplier_q) >> 1);
            mul_cnt_q <= mul_cnt_q + MulCntW'(1);
        end
    end

    // ------------------------------------------------------ stack datapath
    always_comb begin
        stack_d   = stack_q;
        depth_d   = depth_q;
        entry_d   = entry_q;
        count_d   = count_q;
        error_d   = error_q;
        mul_start = 1'b0;

        if (mul_last) begin
            // Product replaces S[1], then S[0] is popped.
            stack_d[0] = mul_result;
            for (int i = 1; i < StackDepth - 1; i++) stack_d[i] = stack_q[i+1];
            stack_d[StackDepth-1] = '0;
            depth_d = depth_q - DepthOne;
        end else if (key_acc) begin
            if (key_if.key_code <= 5'd9) begin
                if (!entry_q) begin
                    if (depth_q < DepthFull) begin
                        for (int i = StackDepth - 1; i > 0; i--) stack_d[i] = stack_q[i-1];
                        stack_d[0] = $signed({{(DataWidth-4){1'b0}}, key_if.key_code[3:0]});
                        depth_d    = depth_q + DepthOne;
                        entry_d    = 1'b1;
                        count_d    = CntOne;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (count_q < CntMax) begin
                    stack_d[0] = append_digit(stack_q[0], key_if.key_code[3:0]);
                    count_d    = count_q + CntOne;
                end
            end else if (key_if.key_code <= KeyClear) begin
                entry_d = 1'b0;
                count_d = '0;
                case (key_if.key_code)
                    KeyEnter: begin
                        // ENTER during entry only terminates the number.
                        if (!entry_q) begin
                            if (depth_q >= DepthOne && depth_q < DepthFull) begin
                                for (int i = StackDepth - 1; i > 0; i--) stack_d[i] = stack_q[i-1];
                                depth_d = depth_q + DepthOne;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                    end
                    KeyAdd, KeySub: begin
                        if (depth_q >= DepthTwo) begin
                            for (int i = 1; i < StackDepth - 1; i++) stack_d[i] = stack_q[i+1];
                            stack_d[StackDepth-1] = '0;
                            stack_d[0] = (key_if.key_code == KeyAdd) ? stack_q[1] + stack_q[0]
                                                                     : stack_q[1] - stack_q[0];
                            depth_d = depth_q - DepthOne;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                    KeyMul: begin
                        if (depth_q >= DepthTwo) mul_start = 1'b1;
                        else                     error_d   = 1'b1;
                    end
                    KeyNeg: begin
                        if (depth_q >= DepthOne) stack_d[0] = -stack_q[0];
                        else                     error_d    = 1'b1;
                    end
                    KeyDrop: begin
                        if (depth_q >= DepthOne) begin
                            for (int i = 0; i < StackDepth - 1; i++) stack_d[i] = stack_q[i+1];
                            stack_d[StackDepth-1] = '0;
                            depth_d = depth_q - DepthOne;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                    KeySwap: begin
                        if (depth_q >= DepthTwo) begin
                            stack_d[0] = stack_q[1];
                            stack_d[1] = stack_q[0];
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                    KeyClear: begin
                        for (int i = 0; i < StackDepth; i++) stack_d[i] = '0;
                        depth_d = '0;
                        error_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            // Codes 18-31 are accepted and have no effect at all.
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < StackDepth; i++) stack_q[i] <= '0;
            depth_q <= '0;
            entry_q <= 1'b0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            stack_q <= stack_d;
            depth_q <= depth_d;
            entry_q <= entry_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign top_o          = stack_q[0];
    assign depth_o        = depth_q;
    assign entry_active_o = entry_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_rpn_calculator.sv
// -----------------------------------------------------------------------------
// tb_rpn_calculator
// Directed testbench for rpn_calculator at default parameters
// (NumDigits=8, DataWidth=32, StackDepth=4).
// -----------------------------------------------------------------------------
module tb_rpn_calculator;

    localparam logic [4:0] K_ENTER = 5'd10;
    localparam logic [4:0] K_ADD   = 5'd11;
    localparam logic [4:0] K_SUB   = 5'd12;
    localparam logic [4:0] K_MUL   = 5'd13;
    localparam logic [4:0] K_NEG   = 5'd14;
    localparam logic [4:0] K_DROP  = 5'd15;
    localparam logic [4:0] K_CLEAR = 5'd17;

    logic        clk;
    logic        rst_n;
    logic [31:0] top;
    logic [2:0]  depth;
    logic        entry;
    logic        err;
    logic        busy;

    int checks;
    int errors;

    rpn_calculator_if kif ();

    rpn_calculator #(
        .NumDigits (8),
        .DataWidth (32),
        .StackDepth(4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .key_if        (kif.slave),
        .top_o         (top),
        .depth_o       (depth),
        .entry_active_o(entry),
        .error_o       (err),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one key, wait (bounded) for ready, and return at edge+1
    // after the edge on which it was accepted.
    task automatic send_key(input logic [4:0] code);
        int waited;
        kif.key_valid = 1'b1;
        kif.key_code  = code;
        waited = 0;
        while (!kif.key_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!kif.key_ready) begin
            $display("FAIL key_ready_timeout: ready=%0b after %0d cycles, required 1", kif.key_ready, waited);
            errors++;
            checks++;
        end
        @(posedge clk); #1;
        kif.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        // Power-on reset, checked while held.
        rst_n = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_code  = 5'd0;
        #2;
        if (top !== 32'd0 || depth !== 3'd0 || err !== 1'b0 || busy !== 1'b0 || kif.key_ready !== 1'b1 || entry !== 1'b0) begin
            $display("FAIL reset_por: top=%0d depth=%0d err=%0b busy=%0b ready=%0b entry=%0b, required 0 0 0 0 1 0",
                     top, depth, err, busy, kif.key_ready, entry);
            errors++;
        end
        checks++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Load some state, then assert reset mid-cycle.
        send_key(5'd5);
        send_key(K_ENTER);
        send_key(K_ENTER);
        send_key(K_ADD);
        send_key(K_ADD);   // underflow -> error set
        if (top !== 32'd10 || depth !== 3'd1 || err !== 1'b1) begin
            $display("FAIL reset_preload: top=%0d depth=%0d err=%0b, required 10 1 1", top, depth, err);
            errors++;
        end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if (top !== 32'd0 || depth !== 3'd0 || err !== 1'b0 || busy !== 1'b0 || kif.key_ready !== 1'b1) begin
            $display("FAIL reset_async: top=%0d depth=%0d err=%0b busy=%0b ready=%0b, required 0 0 0 0 1",
                     top, depth, err, busy, kif.key_ready);
            errors++;
        end
        checks++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub_neg();
        send_key(K_CLEAR);
        send_key(5'd1);
        send_key(5'd2);
        if (top !== 32'd12 || entry !== 1'b1 || depth !== 3'd1) begin
            $display("FAIL entry_12: top=%0d entry=%0b depth=%0d, required 12 1 1", top, entry, depth);
            errors++;
        end
        checks++;
        send_key(K_ENTER);
        send_key(5'd3);
        send_key(5'd4);
        send_key(K_ADD);
        if (top !== 32'd46 || depth !== 3'd1 || entry !== 1'b0 || err !== 1'b0) begin
            $display("FAIL add_46: top=%0d depth=%0d entry=%0b err=%0b, required 46 1 0 0", top, depth, entry, err);
            errors++;
        end
        checks++;
        send_key(K_CLEAR);
        send_key(5'd3);
        send_key(K_ENTER);
        send_key(5'd5);
        send_key(K_SUB);
        if (top !== 32'hFFFF_FFFE || depth !== 3'd1) begin
            $display("FAIL sub_neg2: top=%h depth=%0d, required fffffffe 1", top, depth);
            errors++;
        end
        checks++;
        send_key(K_NEG);
        if (top !== 32'd2 || depth !== 3'd1) begin
            $display("FAIL neg_2: top=%0d depth=%0d, required 2 1", top, depth);
            errors++;
        end
        checks++;
    endtask

    task automatic test_mul_case(input logic [31:0] expect_top, input logic [31:0] pre_top, input string name);
        int busy_bad;
        // MUL key accepted at edge t; we return from send_key at t+1ns.
        send_key(K_MUL);
        if (busy !== 1'b1 || kif.key_ready !== 1'b0 || top !== pre_top || depth !== 3'd2) begin
            $display("FAIL %s_start: busy=%0b ready=%0b top=%h depth=%0d, required 1 0 %h 2",
                     name, busy, kif.key_ready, top, depth, pre_top);
            errors++;
        end
        checks++;
        busy_bad = 0;
        for (int i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1 || kif.key_ready !== 1'b0 || top !== pre_top || depth !== 3'd2) busy_bad++;
        end
        if (busy_bad != 0) begin
            $display("FAIL %s_hold: %0d of 31 cycles left busy/top/depth, required 0", name, busy_bad);
            errors++;
        end
        checks++;
        @(posedge clk); #1;   // edge t+32
        if (busy !== 1'b0 || kif.key_ready !== 1'b1 || top !== expect_top || depth !== 3'd1) begin
            $display("FAIL %s_done: busy=%0b ready=%0b top=%h depth=%0d, required 0 1 %h 1",
                     name, busy, kif.key_ready, top, depth, expect_top);
            errors++;
        end
        checks++;
    endtask

    task automatic test_mul();
        send_key(K_CLEAR);
        send_key(5'd7);
        send_key(K_ENTER);
        send_key(5'd6);
        test_mul_case(32'd42, 32'd6, "mul_7x6");
        send_key(K_CLEAR);
        send_key(5'd3);
        send_key(K_NEG);
        send_key(5'd5);
        test_mul_case(32'hFFFF_FFF1, 32'd5, "mul_m3x5");
        // MUL with a single operand: error, no busy.
        send_key(K_MUL);
        if (err !== 1'b1 || busy !== 1'b0 || depth !== 3'd1 || top !== 32'hFFFF_FFF1) begin
            $display("FAIL mul_underflow: err=%0b busy=%0b depth=%0d top=%h, required 1 0 1 fffffff1", err, busy, depth, top);
            errors++;
        end
        checks++;
    endtask

    task automatic test_underflow();
        send_key(K_CLEAR);
        send_key(5'd9);
        send_key(K_ADD);
        if (err !== 1'b1 || top !== 32'd9 || depth !== 3'd1 || entry !== 1'b0) begin
            $display("FAIL underflow_add: err=%0b top=%0d depth=%0d entry=%0b, required 1 9 1 0", err, top, depth, entry);
            errors++;
        end
        checks++;
        send_key(K_DROP);
        if (depth !== 3'd0 || top !== 32'd0 || err !== 1'b1) begin
            $display("FAIL drop_last: depth=%0d top=%0d err=%0b, required 0 0 1", depth, top, err);
            errors++;
        end
        checks++;
        send_key(K_DROP);
        if (depth !== 3'd0 || err !== 1'b1) begin
            $display("FAIL drop_empty: depth=%0d err=%0b, required 0 1", depth, err);
            errors++;
        end
        checks++;
        send_key(K_CLEAR);
        if (err !== 1'b0 || depth !== 3'd0 || top !== 32'd0) begin
            $display("FAIL clear: err=%0b depth=%0d top=%0d, required 0 0 0", err, depth, top);
            errors++;
        end
        checks++;
    endtask

    task automatic test_overflow_digits();
        send_key(K_CLEAR);
        for (int d = 1; d <= 4; d++) begin
            send_key(5'(d));
            send_key(K_ENTER);
        end
        if (depth !== 3'd4 || top !== 32'd4 || err !== 1'b0) begin
            $display("FAIL fill_stack: depth=%0d top=%0d err=%0b, required 4 4 0", depth, top, err);
            errors++;
        end
        checks++;
        send_key(5'd5);
        if (err !== 1'b1 || depth !== 3'd4 || top !== 32'd4 || entry !== 1'b0) begin
            $display("FAIL overflow_digit: err=%0b depth=%0d top=%0d entry=%0b, required 1 4 4 0", err, depth, top, entry);
            errors++;
        end
        checks++;
        send_key(K_CLEAR);
        for (int d = 1; d <= 9; d++) send_key(5'(d));
        if (top !== 32'd12345678 || depth !== 3'd1 || entry !== 1'b1 || err !== 1'b0) begin
            $display("FAIL digit_limit: top=%0d depth=%0d entry=%0b err=%0b, required 12345678 1 1 0", top, depth, entry, err);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_during_mul();
        send_key(K_CLEAR);
        send_key(5'd7);
        send_key(K_ENTER);
        send_key(5'd6);
        send_key(K_MUL);
        repeat (9) begin
            @(posedge clk); #1;
        end
        if (busy !== 1'b1) begin
            $display("FAIL mulrst_busy: busy=%0b, required 1", busy);
            errors++;
        end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if (busy !== 1'b0 || depth !== 3'd0 || top !== 32'd0 || kif.key_ready !== 1'b1) begin
            $display("FAIL mulrst_abort: busy=%0b depth=%0d top=%0d ready=%0b, required 0 0 0 1", busy, depth, top, kif.key_ready);
            errors++;
        end
        checks++;
        // Present a key during reset, release mid-cycle; first edge accepts it.
        kif.key_valid = 1'b1;
        kif.key_code  = 5'd4;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        kif.key_valid = 1'b0;
        if (depth !== 3'd1 || top !== 32'd4 || entry !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL release_key: depth=%0d top=%0d entry=%0b busy=%0b, required 1 4 1 0", depth, top, entry, busy);
            errors++;
        end
        checks++;
        // A stale multiply must not complete later.
        repeat (30) begin
            @(posedge clk); #1;
        end
        if (depth !== 3'd1 || top !== 32'd4 || busy !== 1'b0) begin
            $display("FAIL release_stable: depth=%0d top=%0d busy=%0b, required 1 4 0", depth, top, busy);
            errors++;
        end
        checks++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_sub_neg();
        test_mul();
        test_underflow();
        test_overflow_digits();
        test_reset_during_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
